// File: rtl/prog_loader.sv
// Streams 16 bytes into a 16-entry CPU program RAM, then releases the CPU from reset.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte before the release.
module prog_loader (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       load_ram,
  output logic [3:0] load_addr,
  output logic [7:0] load_data,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam logic [3:0] LAST_ADDR = 4'd15;
  localparam logic [4:0] COUNT_MAX = 5'd17;

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] sum_q, sum_d;
  logic [4:0] count_q, count_d;
  logic       load_ram_q, load_ram_d;
  logic [3:0] load_addr_q, load_addr_d;
  logic [7:0] load_data_q, load_data_d;
  logic       cpu_reset_q, cpu_reset_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       accept;

  // A pending start blocks the stream so a byte never straddles two sessions.
  always_comb begin
    in_ready = ((state_q == LOAD) || (state_q == CHECK)) && !start;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    count_d     = count_q;
    load_ram_d  = 1'b0;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;

    if (start) begin
      state_d = LOAD;
      addr_d  = '0;
      sum_d   = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (accept) begin
            load_ram_d  = 1'b1;
            load_addr_d = addr_q;
            load_data_d = in_data;
            sum_d       = sum_q + in_data;
            count_d     = (count_q == COUNT_MAX) ? count_q : count_q + 5'd1;
            addr_d      = addr_q + 4'd1;
            if (addr_q == LAST_ADDR) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = RUN;
`endif
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            count_d = (count_q == COUNT_MAX) ? count_q : count_q + 5'd1;
            state_d = (in_data == sum_q) ? RUN : ERR;
          end
        end
`endif
        default: ;
      endcase
    end

    busy_d      = (state_d == LOAD) || (state_d == CHECK);
    done_d      = (state_d == RUN);
    error_d     = (state_d == ERR);
    // Release only once RUN has already been held for a cycle, and re-assert on leaving it.
    cpu_reset_d = !((state_q == RUN) && (state_d == RUN));
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: the reset is sampled on the clock edge, so it is synchronous by construction.
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      load_ram_q  <= 1'b0;
      load_addr_q <= '0;
      load_data_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      load_ram_q  <= load_ram_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign load_ram   = load_ram_q;
  assign load_addr  = load_addr_q;
  assign load_data  = load_data_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised self-checking bench for prog_loader; expectations come from the byte list
// of each session (addresses, data, modulo-256 sum) rather than from a cycle model.
module tb_prog_loader;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_ni;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       load_ram;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] byte_count;

  prog_loader dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .load_ram  (load_ram),
    .load_addr (load_addr),
    .load_data (load_data),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .byte_count(byte_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  logic [3:0] mon_addr[$];
  logic [7:0] mon_data[$];
  int         mon_cyc[$];
  logic [7:0] exp_bytes[16];

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  // Every write strobe seen mid-cycle is logged with the cycle it appeared in.
  always @(negedge wb_clk_i) begin
    if (load_ram === 1'b1) begin
      mon_addr.push_back(load_addr);
      mon_data.push_back(load_data);
      mon_cyc.push_back(cyc_n);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge; in_ready is sampled mid-cycle.
  task automatic cyc(input logic s, input logic v, input logic [7:0] d, input logic exp_rdy);
    start    = s;
    in_valid = v;
    in_data  = d;
    @(negedge wb_clk_i);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_ram", 32'(load_ram), 32'd0);
    check("rst_load_addr", 32'(load_addr), 32'd0);
    check("rst_load_data", 32'(load_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic status(input string tag, input logic b, input logic dn, input logic er,
                        input logic cr, input int cnt);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(dn));
    check({tag, "_error"}, 32'(error), 32'(er));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
    check({tag, "_byte_count"}, 32'(byte_count), 32'(cnt));
  endtask

  function automatic logic [7:0] sum16();
    int s = 0;
    for (int i = 0; i < 16; i++) s += exp_bytes[i];
    return 8'(s % 256);
  endfunction

  task automatic begin_session();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
    cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    status("start", 1'b1, 1'b0, 1'b0, 1'b1, 0);
    check("start_load_ram", 32'(load_ram), 32'd0);
  endtask

  // mode 0: every cycle, 1: alternate valid/idle, 2: random valid.
  task automatic send_bytes(input int n, input int mode);
    int   got   = 0;
    int   guard = 0;
    logic v;
    logic tog   = 1'b1;
    while (got < n && guard < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      cyc(1'b0, v, v ? exp_bytes[got] : 8'($urandom), 1'b1);
      if (v) got++;
      guard++;
    end
    check("send_guard", 32'(got), 32'(n));
    check("send_byte_count", 32'(byte_count), 32'(n));
  endtask

  task automatic check_pulses(input string tag, input int n, input int gap);
    check({tag, "_pulse_count"}, 32'(mon_addr.size()), 32'(n));
    for (int i = 0; i < n && i < mon_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(mon_addr[i]), 32'(i));
      check({tag, "_data"}, 32'(mon_data[i]), 32'(exp_bytes[i]));
      if (gap > 0 && i > 0) check({tag, "_gap"}, 32'(mon_cyc[i] - mon_cyc[i-1]), 32'(gap));
    end
  endtask

  // Called right after the 16th byte was accepted.
  task automatic finish_session(input string tag, input logic [7:0] chk);
`ifdef PROG_LOADER_CHECKSUM_EN
    logic good;
    good = (chk == sum16());
    status({tag, "_chk"}, 1'b1, 1'b0, 1'b0, 1'b1, 16);
    check({tag, "_last_addr"}, 32'(load_addr), 32'd15);
    cyc(1'b0, 1'b1, chk, 1'b1);
    status({tag, "_end1"}, 1'b0, good, !good, 1'b1, 17);
    check({tag, "_no17th"}, 32'(load_ram), 32'd0);
    cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    status({tag, "_end2"}, 1'b0, good, !good, !good, 17);
    repeat (3) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    status({tag, "_hold"}, 1'b0, good, !good, !good, 17);
`else
    status({tag, "_end1"}, 1'b0, 1'b1, 1'b0, 1'b1, 16);
    check({tag, "_last_pulse"}, 32'(load_ram), 32'd1);
    check({tag, "_last_addr"}, 32'(load_addr), 32'd15);
    cyc(1'b0, 1'b1, chk, 1'b0);
    status({tag, "_end2"}, 1'b0, 1'b1, 1'b0, 1'b0, 16);
    repeat (3) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    status({tag, "_hold"}, 1'b0, 1'b1, 1'b0, 1'b0, 16);
`endif
  endtask

  initial begin
    wb_rst_ni = 1'b0;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    repeat (2) @(posedge wb_clk_i);
    #1;
    check_reset_values();
    wb_rst_ni = 1'b1;
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    status("idle", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check("idle_no_pulse", 32'(mon_addr.size()), 32'd0);

    // Bytes 0x00..0x0F back to back, correct checksum 0x78.
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'(i);
    begin_session();
    send_bytes(16, 0);
    finish_session("seq", 8'h78);
    check_pulses("seq", 16, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
    begin_session();
    send_bytes(16, 0);
    finish_session("badsum", 8'h77);
    check_pulses("badsum", 16, 1);
`endif

    // Alternating valid gives one idle cycle between strobes.
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'hA0 + 8'(i);
    begin_session();
    send_bytes(16, 1);
    finish_session("toggle", sum16());
    check_pulses("toggle", 16, 2);

    // Restart after 5 bytes with a byte presented alongside start.
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'($urandom);
    begin_session();
    send_bytes(5, 0);
    cyc(1'b1, 1'b1, ~exp_bytes[0], 1'b0);
    status("restart", 1'b1, 1'b0, 1'b0, 1'b1, 0);
    check("restart_load_ram", 32'(load_ram), 32'd0);
    check_pulses("restart_old", 5, 1);
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
    send_bytes(1, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check_pulses("restart_new", 1, 0);

    // Reset after byte 9 while byte 10 is being offered.
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'($urandom);
    begin_session();
    send_bytes(9, 0);
    wb_rst_ni = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b1;
    in_data   = exp_bytes[9];
    @(negedge wb_clk_i);
    check("rst_sync_busy", 32'(busy), 32'd1);
    @(posedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b1;
    check_reset_values();
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_after_load_ram", 32'(load_ram), 32'd0);
    check_pulses("rst_mid", 9, 1);

    // All 0xFF: the modulo-256 sum is 0xF0.
    for (int i = 0; i < 16; i++) exp_bytes[i] = 8'hFF;
    begin_session();
    send_bytes(16, 0);
    finish_session("ff", 8'hF0);
    check_pulses("ff", 16, 1);

    repeat (4) begin
      logic [7:0] c;
      for (int i = 0; i < 16; i++) exp_bytes[i] = 8'($urandom);
      begin_session();
      send_bytes(16, 2);
      c = ($urandom_range(0, 1) == 1) ? sum16() : 8'($urandom);
      finish_session("rand", c);
      check_pulses("rand", 16, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
